// File: rtl/core_inst_sequencer_if.sv
// core_inst_sequencer_if: host start/done and core inst/ofifo_valid bundle; stall_cycles present under SEQ_PERF_CNT_EN
interface core_inst_sequencer_if;
  logic start, ofifo_valid, busy, done;
  logic [33:0] inst;
  logic [3:0] kij_idx;
`ifdef SEQ_PERF_CNT_EN
  logic [15:0] stall_cycles;
  modport master(output start, ofifo_valid, input inst, busy, done, kij_idx, stall_cycles);
  modport slave(input start, ofifo_valid, output inst, busy, done, kij_idx, stall_cycles);
`else
  modport master(output start, ofifo_valid, input inst, busy, done, kij_idx);
  modport slave(input start, ofifo_valid, output inst, busy, done, kij_idx);
`endif
endinterface

// File: rtl/core_inst_sequencer.sv
// core_inst_sequencer: registered per-cycle 34-bit core inst generator for one conv layer; SEQ_PERF_CNT_EN adds stall_cycles
module core_inst_sequencer #(
  parameter int row = 4,
  parameter int col = 8,
  parameter int NUM_KIJ = 9,
  parameter int LEN_NIJ = 36,
  parameter int LEN_ONIJ = 16,
  parameter int W_BASE = 0,
  parameter int X_BASE = 512,
  parameter int P_BASE = 0
) (
  input logic clk,
  input logic reset,
  core_inst_sequencer_if.slave bus
);
  localparam logic [33:0] IDLE_INST = 34'h1_800C_0000;
  localparam logic [3:0] IDLE = 4'd0, W_L0 = 4'd1, W_LOAD = 4'd2, GAP = 4'd3, X_L0 = 4'd4,
                         EXEC = 4'd5, DS = 4'd6, DR = 4'd7, DW = 4'd8, DONE = 4'd9;
  localparam logic [15:0] W_END = 16'(col), LOAD_END = 16'(col - 1), GAP_END = 16'(row + col - 1),
                          X_END = 16'(LEN_NIJ), EXEC_END = 16'(LEN_NIJ - 1), O_END = 16'(LEN_ONIJ - 1);
  localparam logic [3:0] K_END = 4'(NUM_KIJ - 1);
  logic [3:0] state, nxt, kij, nxt_kij;
  logic [15:0] ctr, nxt_ctr;
  logic rd_x, p_en, wr_p;
  logic [9:0] a_x;
  logic [10:0] a_p;
  logic [33:0] nxt_inst;
  always_comb begin
    nxt = state;
    nxt_ctr = ctr + 16'd1;
    nxt_kij = kij;
    case (state)
      IDLE: begin
        nxt_ctr = '0;
        if (bus.start) begin nxt = W_L0; nxt_kij = '0; end
      end
      W_L0: if (ctr == W_END) begin nxt = W_LOAD; nxt_ctr = '0; end
      W_LOAD: if (ctr == LOAD_END) begin nxt = GAP; nxt_ctr = '0; end
      GAP: if (ctr == GAP_END) begin nxt = X_L0; nxt_ctr = '0; end
      X_L0: if (ctr == X_END) begin nxt = EXEC; nxt_ctr = '0; end
      EXEC: if (ctr == EXEC_END) begin nxt = bus.ofifo_valid ? DR : DS; nxt_ctr = '0; end
      DS: begin nxt = bus.ofifo_valid ? DR : DS; nxt_ctr = ctr; end
      DR: begin nxt = DW; nxt_ctr = ctr; end
      DW:
        if (ctr != O_END) nxt = bus.ofifo_valid ? DR : DS;
        else if (kij == K_END) begin nxt = DONE; nxt_ctr = '0; end
        else begin nxt = W_L0; nxt_ctr = '0; nxt_kij = kij + 4'd1; end
      default: begin nxt = IDLE; nxt_ctr = '0; end
    endcase
  end
  // inst is built from the next state so every output leaves a flop
  always_comb begin
    rd_x = (nxt == W_L0 && nxt_ctr < W_END) || (nxt == X_L0 && nxt_ctr < X_END);
    a_x = nxt == W_L0 ? 10'(W_BASE) + 10'(nxt_kij) * 10'(col) + nxt_ctr[9:0] : 10'(X_BASE) + nxt_ctr[9:0];
    a_p = 11'(P_BASE) + nxt_ctr[10:0];
    p_en = nxt == DR || nxt == DW;
    wr_p = nxt == DW;
    nxt_inst = {wr_p && nxt_kij != 4'd0, !p_en, !wr_p, p_en ? a_p : 11'd0, !rd_x, 1'b1,
                rd_x ? {1'b0, a_x} : 11'd0, wr_p, 2'b00, nxt == W_LOAD || nxt == EXEC,
                (nxt == W_L0 || nxt == X_L0) && nxt_ctr != '0, nxt == EXEC, nxt == W_LOAD};
  end
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      ctr <= '0;
      kij <= '0;
      bus.inst <= IDLE_INST;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.kij_idx <= '0;
    end else begin
      state <= nxt;
      ctr <= nxt_ctr;
      kij <= nxt_kij;
      bus.inst <= nxt_inst;
      bus.busy <= nxt != IDLE && nxt != DONE;
      bus.done <= nxt == DONE;
      bus.kij_idx <= nxt_kij;
    end
`ifdef SEQ_PERF_CNT_EN
  always_ff @(posedge clk)
    if (reset || (state == IDLE && bus.start)) bus.stall_cycles <= '0;
    else if (nxt == DS && bus.stall_cycles != 16'hFFFF) bus.stall_cycles <= bus.stall_cycles + 16'd1;
`endif
endmodule

// File: tb/tb_core_inst_sequencer.sv
// tb_core_inst_sequencer: vector table, directed drain/abort/done sequences and random ofifo stalls against a queue-based layer model
module tb_core_inst_sequencer;
  localparam int ROW = 4, COL = 8, NKIJ = 9, NIJ = 36, ONIJ = 16, WB = 0, XB = 512, PB = 0;
  localparam int LAYER = NKIJ * (2 * COL + 1 + ROW + COL + 2 * NIJ + 1 + 2 * ONIJ) + 1;
  localparam logic [33:0] IDLE_I = 34'h1_800C_0000;
  typedef struct { logic [33:0] inst; logic [3:0] kij; bit is_rd; } item_t;
  typedef struct { logic rst, st; logic [33:0] inst; logic busy, done; logic [3:0] kij; } vec_t;
  logic clk = 0, reset;
  int checks = 0, errors = 0;
  item_t q[$];
  core_inst_sequencer_if bus();
  core_inst_sequencer #(.row(ROW), .col(COL), .NUM_KIJ(NKIJ), .LEN_NIJ(NIJ), .LEN_ONIJ(ONIJ),
                        .W_BASE(WB), .X_BASE(XB), .P_BASE(PB)) dut (.clk(clk), .reset(reset), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [39:0] got, input logic [39:0] exp, output bit ok);
    checks++;
    ok = (got === exp);
    if (!ok) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask
  function automatic logic [33:0] mk(bit acc, bit cenp, bit wenp, int ap, bit cenx, int ax, bit ord, bit l0rd, bit l0wr, bit ex, bit ld);
    return {acc, cenp, wenp, 11'(ap), cenx, 1'b1, 11'(ax % 1024), ord, 2'b00, l0rd, l0wr, ex, ld};
  endfunction
  task automatic build();
    q.delete();
    for (int k = 0; k < NKIJ; k++) begin
      for (int c = 0; c <= COL; c++) q.push_back('{mk(0, 1, 1, 0, c == COL, c < COL ? WB + k * COL + c : 0, 0, 0, c > 0, 0, 0), 4'(k), 1'b0});
      for (int c = 0; c < COL; c++) q.push_back('{mk(0, 1, 1, 0, 1, 0, 0, 1, 0, 0, 1), 4'(k), 1'b0});
      for (int c = 0; c < ROW + COL; c++) q.push_back('{IDLE_I, 4'(k), 1'b0});
      for (int n = 0; n <= NIJ; n++) q.push_back('{mk(0, 1, 1, 0, n == NIJ, n < NIJ ? XB + n : 0, 0, 0, n > 0, 0, 0), 4'(k), 1'b0});
      for (int n = 0; n < NIJ; n++) q.push_back('{mk(0, 1, 1, 0, 1, 0, 0, 1, 0, 1, 0), 4'(k), 1'b0});
      for (int o = 0; o < ONIJ; o++) begin
        q.push_back('{mk(0, 0, 1, PB + o, 1, 0, 0, 0, 0, 0, 0), 4'(k), 1'b1});
        q.push_back('{mk(k != 0, 0, 0, PB + o, 1, 0, 1, 0, 0, 0, 0), 4'(k), 1'b0});
      end
    end
  endtask
  // mode 0: ofifo_valid tied 1; 1: 5-cycle stall at o=3 of kij 2; 2: random valid and stray starts; 3: reset in EXEC of kij 4
  task automatic run_layer(input int mode);
    item_t it;
    int cyc = 0, stalls = 0, stall_left = 0, wr_idx = 0, ap_bad = 0, acc_bad = 0, first_w = -1, first_x = -1;
    bit seen_load = 0, ok = 1, fin = 0, aborted = 0;
    logic [3:0] last_k = 4'hF;
    build();
    bus.start = 1;
    while (!fin) begin
      @(negedge clk);
      bus.start = (mode == 2) ? ($urandom_range(0, 15) == 0) : 1'b0;
      cyc++;
      if (cyc > 4 * LAYER) begin
        check("timeout", 40'(cyc), 40'(LAYER), ok);
        fin = 1;
      end else if (q.size() == 0) begin
        check("done_cycle", {bus.inst, bus.busy, bus.done, 4'h0}, {IDLE_I, 2'b01, 4'h0}, ok);
        if (ok) check("layer_len", 40'(cyc), 40'(LAYER + (mode == 1 ? 5 : stalls)), ok);
        fin = 1;
      end else begin
        if (q[0].is_rd && !bus.ofifo_valid) begin
          it = '{IDLE_I, q[0].kij, 1'b0};
          stalls++;
        end else it = q.pop_front();
        check("stream", {bus.inst, bus.busy, bus.done, bus.kij_idx}, {it.inst, 2'b10, it.kij}, ok);
        fin = !ok;
        if (ok) begin
          if (bus.inst[6]) begin
            if (bus.kij_idx != last_k) wr_idx = 0;
            last_k = bus.kij_idx;
            ap_bad += int'(bus.inst[30:20] != 11'(PB + wr_idx));
            acc_bad += int'(bus.inst[33] != (bus.kij_idx != 4'd0));
            wr_idx++;
          end
          if (bus.kij_idx == 4'd0 && !bus.inst[19]) begin
            if (first_w < 0) first_w = int'(bus.inst[17:7]);
            else if (seen_load && first_x < 0) first_x = int'(bus.inst[17:7]);
          end
          if (bus.kij_idx == 4'd0 && bus.inst[0]) seen_load = 1;
          if (mode == 1 && bus.inst[6] && bus.kij_idx == 4'd2 && bus.inst[30:20] == 11'(PB + 2)) stall_left = 5;
          bus.ofifo_valid = (mode == 2) ? ($urandom_range(0, 2) != 0) : (stall_left == 0);
          if (stall_left > 0) stall_left--;
          if (mode == 3 && bus.kij_idx == 4'd4 && bus.inst[1]) begin
            reset = 1;
            @(negedge clk);
            check("abort", {bus.inst, bus.busy, bus.done, bus.kij_idx}, {IDLE_I, 2'b00, 4'h0}, ok);
            reset = 0;
            aborted = 1;
            fin = 1;
          end
        end
      end
    end
    bus.start = 0;
    bus.ofifo_valid = 1;
    if (!ok) begin
      reset = 1;
      repeat (2) @(negedge clk);
      reset = 0;
      return;
    end
    if (aborted) return;
    bus.start = 1;
    @(negedge clk);
    check("start_on_done", {bus.inst, bus.busy, bus.done, 4'h0}, {IDLE_I, 2'b00, 4'h0}, ok);
    bus.start = 0;
    @(negedge clk);
    check("idle_after_done", {bus.inst, bus.busy, bus.done, 4'h0}, {IDLE_I, 2'b00, 4'h0}, ok);
    check("ap_steps", 40'(ap_bad), 40'h0, ok);
    check("accum", 40'(acc_bad), 40'h0, ok);
    check("first_w", 40'(first_w), 40'(WB), ok);
    check("first_x", 40'(first_x), 40'(XB), ok);
`ifdef SEQ_PERF_CNT_EN
    check("stall_cycles", 40'(bus.stall_cycles), 40'(stalls), ok);
`endif
  endtask
  initial begin
    vec_t tbl[11];
    bit ok;
    tbl = '{
      '{1'b1, 1'b0, IDLE_I, 1'b0, 1'b0, 4'h0},
      '{1'b1, 1'b0, IDLE_I, 1'b0, 1'b0, 4'h0},
      '{1'b1, 1'b0, IDLE_I, 1'b0, 1'b0, 4'h0},
      '{1'b0, 1'b0, IDLE_I, 1'b0, 1'b0, 4'h0},
      '{1'b0, 1'b1, 34'h1_8004_0000, 1'b1, 1'b0, 4'h0},
      '{1'b0, 1'b0, 34'h1_8004_0084, 1'b1, 1'b0, 4'h0},
      '{1'b0, 1'b1, 34'h1_8004_0104, 1'b1, 1'b0, 4'h0},
      '{1'b0, 1'b0, 34'h1_8004_0184, 1'b1, 1'b0, 4'h0},
      '{1'b1, 1'b0, IDLE_I, 1'b0, 1'b0, 4'h0},
      '{1'b1, 1'b1, IDLE_I, 1'b0, 1'b0, 4'h0},
      '{1'b0, 1'b0, IDLE_I, 1'b0, 1'b0, 4'h0}
    };
    reset = 1;
    bus.start = 0;
    bus.ofifo_valid = 1;
    for (int i = 0; i < 11; i++) begin
      reset = tbl[i].rst;
      bus.start = tbl[i].st;
      @(negedge clk);
      check($sformatf("vec%0d", i), {bus.inst, bus.busy, bus.done, bus.kij_idx},
            {tbl[i].inst, tbl[i].busy, tbl[i].done, tbl[i].kij}, ok);
    end
    bus.start = 0;
    run_layer(0);
    run_layer(1);
    run_layer(3);
    run_layer(0);
    run_layer(2);
    run_layer(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
